// File: rtl/memory_stage.sv
// memory_stage: M pipeline register plus byte-addressed data memory access.
// clk/rst in; e_* execute results in; M_* register out; m_* results to W.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        M_stall,
  input  logic        M_bubble,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [1:0]  m_stat,
  output logic [3:0]  m_icode,
  output logic [63:0] m_valE,
  output logic [63:0] m_valM,
  output logic [3:0]  m_dstE,
  output logic [3:0]  m_dstM
);

  localparam int AW =
    (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] LAST =
    64'(MEM_BYTES - 8);

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] R_NONE   = 4'hF;

  logic [1:0] M_stat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else if (!M_stall) begin
      if (M_bubble) begin
        M_stat  <= STAT_AOK;
        M_icode <= I_NOP;
        M_Cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= R_NONE;
        M_dstM  <= R_NONE;
      end else begin
        M_stat  <= e_stat;
        M_icode <= e_icode;
        M_Cnd   <= e_Cnd;
        M_valE  <= e_valE;
        M_valA  <= e_valA;
        M_dstE  <= e_dstE;
        M_dstM  <= e_dstM;
      end
    end
  end

  logic        rd;
  logic        wr;
  logic [63:0] addr;

  // ret/popq address through the old stack pointer in valA
  always_comb begin
    rd   = 1'b0;
    wr   = 1'b0;
    addr = M_valE;
    unique case (M_icode)
      4'h4, 4'h8, 4'hA: wr = 1'b1;
      4'h5: rd = 1'b1;
      4'h9, 4'hB: begin
        rd   = 1'b1;
        addr = M_valA;
      end
      default: ;
    endcase
  end

  // full-width compare: a huge addr must not alias low memory
  logic          ok;
  logic [AW-1:0] base;
  logic          we;

  assign ok   = addr <= LAST;
  assign base = addr[AW-1:0];
  assign we   = wr && ok && (M_stat == STAT_AOK) && !rst;

  logic [7:0]  mem [MEM_BYTES];
  logic [63:0] rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 8; k++)
        mem[base + AW'(k)] <= M_valA[8*k +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && ok) begin
      for (int k = 0; k < 8; k++)
        rdata[8*k +: 8] = mem[base + AW'(k)];
    end
  end

  assign m_valM  = rdata;
  assign m_stat  = ((rd || wr) && !ok) ? STAT_ADR : M_stat;
  assign m_icode = M_icode;
  assign m_valE  = M_valE;
  assign m_dstE  = M_dstE;
  assign m_dstM  = M_dstM;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed + random checks of memory_stage
// against a byte-array reference model.
module tb_memory_stage;
  localparam int MB = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]  e_stat = '0;
  logic [3:0]  e_icode = 4'h1;
  logic        e_Cnd = 1'b0;
  logic [63:0] e_valE = '0;
  logic [63:0] e_valA = '0;
  logic [3:0]  e_dstE = 4'hF;
  logic [3:0]  e_dstM = 4'hF;
  logic        M_stall = 1'b0;
  logic        M_bubble = 1'b0;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [1:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;

  always #5 clk = ~clk;

  memory_stage #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst),
    .e_stat(e_stat), .e_icode(e_icode),
    .e_Cnd(e_Cnd), .e_valE(e_valE),
    .e_valA(e_valA), .e_dstE(e_dstE),
    .e_dstM(e_dstM),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_stat(m_stat), .m_icode(m_icode),
    .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // reference model state
  logic [7:0]  rmem [MB];
  logic [1:0]  r_stat;
  logic [3:0]  r_icode;
  logic        r_cnd;
  logic [63:0] r_valE;
  logic [63:0] r_valA;
  logic [3:0]  r_dstE;
  logic [3:0]  r_dstM;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_nop();
    r_stat = 2'b00; r_icode = 4'h1; r_cnd = 1'b0;
    r_valE = '0; r_valA = '0;
    r_dstE = 4'hF; r_dstM = 4'hF;
  endtask

  // memory behaviour of the instruction held in M
  task automatic acc(output bit rd, output bit wr,
                     output bit ok,
                     output logic [63:0] a);
    rd = r_icode inside {4'h5, 4'h9, 4'hB};
    wr = r_icode inside {4'h4, 4'h8, 4'hA};
    a  = (r_icode inside {4'h9, 4'hB}) ? r_valA : r_valE;
    ok = a <= 64'(MB - 8);
  endtask

  task automatic model_edge();
    bit rd, wr, ok;
    logic [63:0] a;
    acc(rd, wr, ok, a);
    if (wr && ok && r_stat == 2'b00)
      for (int k = 0; k < 8; k++)
        rmem[int'(a) + k] = r_valA[8*k +: 8];
    if (!M_stall) begin
      if (M_bubble) model_nop();
      else begin
        r_stat = e_stat; r_icode = e_icode;
        r_cnd = e_Cnd; r_valE = e_valE;
        r_valA = e_valA; r_dstE = e_dstE;
        r_dstM = e_dstM;
      end
    end
  endtask

  task automatic check_all(input string t);
    bit rd, wr, ok;
    logic [63:0] a;
    logic [63:0] ev;
    logic [1:0]  es;
    acc(rd, wr, ok, a);
    ev = '0;
    if (rd && ok)
      for (int k = 0; k < 8; k++)
        ev[8*k +: 8] = rmem[int'(a) + k];
    es = ((rd || wr) && !ok) ? 2'b10 : r_stat;
    check({t, ".m_stat"}, 64'(m_stat), 64'(es));
    check({t, ".m_valM"}, m_valM, ev);
    check({t, ".m_icode"}, 64'(m_icode), 64'(r_icode));
    check({t, ".m_valE"}, m_valE, r_valE);
    check({t, ".m_dstE"}, 64'(m_dstE), 64'(r_dstE));
    check({t, ".m_dstM"}, 64'(m_dstM), 64'(r_dstM));
    check({t, ".M_icode"}, 64'(M_icode), 64'(r_icode));
    check({t, ".M_Cnd"}, 64'(M_Cnd), 64'(r_cnd));
    check({t, ".M_valE"}, M_valE, r_valE);
    check({t, ".M_valA"}, M_valA, r_valA);
    check({t, ".M_dstE"}, 64'(M_dstE), 64'(r_dstE));
    check({t, ".M_dstM"}, 64'(M_dstM), 64'(r_dstM));
  endtask

  task automatic drive(input logic [1:0] s,
                       input logic [3:0] ic,
                       input logic [63:0] ve,
                       input logic [63:0] va);
    e_stat = s; e_icode = ic; e_Cnd = ic[0];
    e_valE = ve; e_valA = va;
    e_dstE = ic; e_dstM = ~ic;
  endtask

  task automatic tick(input string t);
    model_edge();
    @(posedge clk);
    #1;
    check_all(t);
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] v;
    model_nop();
    // reset between edges, no clock edge needed
    #2 rst = 1'b1;
    #1;
    check("rst.M_icode", 64'(M_icode), 64'h1);
    check("rst.M_dstE", 64'(M_dstE), 64'hF);
    check("rst.m_stat", 64'(m_stat), 64'h0);
    check("rst.m_valM", m_valM, 64'h0);
    check("rst.M_Cnd", 64'(M_Cnd), 64'h0);
    drive(2'b00, 4'h4, 64'h0, 64'h1);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk) rst = 1'b0;

    // fill memory so every read is defined
    for (int i = 0; i < MB / 8; i++) begin
      drive(2'b00, 4'h4, 64'(8 * i), r64());
      tick("init");
    end
    drive(2'b00, 4'h1, 0, 0);
    tick("init_end");

    // write then read back next cycle
    drive(2'b00, 4'h4, 64'h10, 64'h1122334455667788);
    tick("wr10");
    drive(2'b00, 4'h5, 64'h10, 64'h0);
    tick("rd10");
    check("rd10.val", m_valM, 64'h1122334455667788);
    check("rd10.stat", 64'(m_stat), 64'h0);

    // address boundary
    drive(2'b00, 4'h5, 64'h3F9, 64'h0);
    tick("rd3f9");
    check("rd3f9.stat", 64'(m_stat), 64'h2);
    check("rd3f9.val", m_valM, 64'h0);
    drive(2'b00, 4'h4, 64'h3F9, r64());
    tick("wr3f9");
    check("wr3f9.stat", 64'(m_stat), 64'h2);
    drive(2'b00, 4'h5, 64'h3F8, 64'h0);
    tick("rd3f8");
    check("rd3f8.stat", 64'(m_stat), 64'h0);
    drive(2'b00, 4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    tick("rdwrap");
    check("rdwrap.stat", 64'(m_stat), 64'h2);

    // unaligned write, byte lanes of aligned reads
    drive(2'b00, 4'h4, 64'h13, 64'hAABBCCDDEEFF0011);
    tick("wr13");
    drive(2'b00, 4'h5, 64'h10, 64'h0);
    tick("rd10b");
    check("byte13", 64'(m_valM[31:24]), 64'h11);
    drive(2'b00, 4'h5, 64'h18, 64'h0);
    tick("rd18");
    check("byte1a", 64'(m_valM[23:16]), 64'hAA);

    // stall holds, bubble inserts nop
    drive(2'b00, 4'h9, 64'h30, 64'h20);
    tick("ret");
    M_stall = 1'b1;
    drive(2'b00, 4'h5, 64'h40, 64'h7);
    tick("stall1");
    drive(2'b01, 4'hA, 64'h50, 64'h8);
    M_bubble = 1'b1;
    tick("stall2");
    check("stall.icode", 64'(M_icode), 64'h9);
    M_stall = 1'b0;
    tick("bubble");
    check("bub.icode", 64'(M_icode), 64'h1);
    check("bub.dstE", 64'(M_dstE), 64'hF);
    check("bub.dstM", 64'(M_dstM), 64'hF);
    M_bubble = 1'b0;

    // halted pushq must not write
    v = r64();
    drive(2'b01, 4'hA, 64'h40, v);
    tick("hltpush");
    check("hlt.stat", 64'(m_stat), 64'h1);
    drive(2'b00, 4'h5, 64'h40, 64'h0);
    tick("hltrd");

    // reset landing on a write edge cancels it
    drive(2'b00, 4'h4, 64'h80, r64());
    tick("wr80");
    #3 rst = 1'b1;
    model_nop();
    #1;
    check("rstmid.icode", 64'(M_icode), 64'h1);
    drive(2'b00, 4'h5, 64'h80, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all("rstmid");
    tick("rd80");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ic;
      logic [1:0] st;
      logic [63:0] ad;
      ic = 4'($urandom_range(0, 11));
      st = ($urandom_range(0, 7) == 0) ?
           2'($urandom_range(1, 3)) : 2'b00;
      ad = ($urandom_range(0, 9) == 0) ?
           r64() : 64'($urandom_range(0, MB + 8));
      if (ic inside {4'h9, 4'hB}) drive(st, ic, r64(), ad);
      else drive(st, ic, ad, r64());
      e_dstE = 4'($urandom);
      e_dstM = 4'($urandom);
      e_Cnd  = 1'($urandom);
      M_stall  = ($urandom_range(0, 7) == 0);
      M_bubble = ($urandom_range(0, 7) == 0);
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning data-memory size in bytes.
REQ-002 SHALL have ports: clk  in  1  pipeline clock; rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have inputs: e_stat 2, e_icode 4, e_Cnd 1, e_valE 64, e_valA 64, e_dstE 4, e_dstM 4, meaning execute-stage results.
REQ-004 SHALL have inputs: M_stall  1  hold M register; M_bubble  1  load nop into M register.
REQ-005 SHALL have M-register outputs: M_icode 4, M_Cnd 1, M_valE 64, M_valA 64, M_dstE 4, M_dstM 4, for forwarding and hazard control.
REQ-006 SHALL have outputs: m_stat 2, m_icode 4, m_valE 64, m_valM 64, m_dstE 4, m_dstM 4, meaning memory-stage results feeding the writeback register.
REQ-007 SHALL use stat encoding 00 AOK, 01 HLT, 10 ADR, 11 INS, and register ID 4'hF as "none".

Function
REQ-008 SHALL hold an M pipeline register of stat, icode, Cnd, valE, valA, dstE, dstM, updated on rising clk.
REQ-009 SHALL load the M register from e_* each edge when M_stall=0 and M_bubble=0.
REQ-010 SHALL hold the M register unchanged when M_stall=1, regardless of M_bubble.
REQ-011 SHALL, when M_bubble=1 and M_stall=0, load a nop: stat AOK, icode 1, Cnd 0, valE 0, valA 0, dstE F, dstM F.
REQ-012 SHALL compute the address combinationally from the M register: valE for icode 4, 5, 8, A; valA for icode 9, B.
REQ-013 SHALL read for icode 5, 9, B; write for icode 4, 8, A; perform no access for other icodes.
REQ-014 SHALL treat an access as valid only if addr <= MEM_BYTES-8, compared in full 64 bits with no wrap-around.
REQ-015 SHALL hold byte-addressed memory; an access covers 8 bytes little-endian, addr (LSB) through addr+7; unaligned addresses are allowed.
REQ-016 SHALL read combinationally: m_valM equals the 8 bytes at the address when a valid read occurs, otherwise 0.
REQ-017 SHALL write M_valA at the rising clk edge only when the write is valid, M_stat=AOK, and rst=0.
REQ-018 SHALL set m_stat to ADR on an invalid read or write address, otherwise to M_stat.
REQ-019 SHALL pass m_icode, m_valE, m_dstE, m_dstM through unchanged from the M register.
REQ-020 SHALL, when a write and a read of overlapping bytes fall in consecutive cycles, return the newly written data to the read.
REQ-021 SHALL, when a read and write to the same address fall in the same cycle, read the pre-write data (one instruction per cycle, so only across pipeline boundaries).

Reset
REQ-022 SHALL, while rst=1, force the M register to the nop values of REQ-011 asynchronously, independent of clk.
REQ-023 SHALL give reset outputs: m_stat AOK, m_icode 1, m_valM 0, m_valE 0, dstE/dstM F, M_Cnd 0.
REQ-024 SHALL leave memory contents uninitialised by reset and suppress writes while rst=1.
REQ-025 SHALL, when rst asserts mid-write-cycle, perform no write at that edge.

Verification
REQ-026 SHALL pass this scenario: rst pulse between clock edges -> M_icode=1, dstE=F, m_stat=00 immediately, without a clock edge.
REQ-027 SHALL pass this scenario: e_icode=4, valE=0x10, valA=0x1122334455667788; next cycle e_icode=5, valE=0x10 -> second-cycle m_valM=0x1122334455667788, m_stat=00.
REQ-028 SHALL pass this scenario: icode=5, valE=0x3F9 with MEM_BYTES=1024 -> m_stat=10, m_valM=0; icode=4 at the same address -> m_stat=10 and memory unchanged.
REQ-029 SHALL pass this scenario: unaligned write to 0x13 of 0xAABBCCDDEEFF0011, then reads at 0x10 and 0x18 -> byte 0x13=0x11 and byte 0x1A=0xAA appear at the correct lanes.
REQ-030 SHALL pass this scenario: load icode=9 (ret); assert M_stall for 2 cycles with changing e_* -> M outputs hold; then M_bubble=1 -> M_icode=1, dstE=F, dstM=F.
REQ-031 SHALL pass this scenario: e_stat=01 (HLT), icode=A (pushq) with valid address -> no memory write, m_stat=01.
